// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, with a registered
// carry loop and a start/busy/done handshake.

module full_adder_structural (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic axb;
    logic gen;
    logic prop;

    assign axb  = a ^ b;
    assign s    = axb ^ ci;
    assign gen  = a & b;
    assign prop = axb & ci;
    assign co   = gen | prop;
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fa_s;
    logic fa_co;

    full_adder_structural u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    s_sr_d  = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                s_sr_d = {fa_s, s_sr_q[WIDTH-1:1]};
                c_d    = fa_co;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake flags follow the next state so they line up with it.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, multi-cycle corner
// sequences, random operands against a+b+cin, and an exhaustive WIDTH=4 sweep.

module tb_serial_adder;
    logic       clk;
    logic       rst;

    logic       s8, c8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       s4, c4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[6];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (s8),
        .a     (a8),
        .b     (b8),
        .cin   (c8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (s4),
        .a     (a4),
        .b     (b4),
        .cin   (c4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for done", nm);
    endtask

    // One WIDTH=8 operation; operands are scrambled after acceptance.
    task automatic op8(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic [7:0] es, input logic ec);
        int nb;
        bit seen;
        @(negedge clk);
        s8 = 1'b1; a8 = ta; b8 = tb_; c8 = tc;
        @(negedge clk);
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        nb = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                seen = 1;
                break;
            end
            if (busy8) nb++;
            @(negedge clk);
        end
        if (!seen) begin
            timeout(nm);
        end else begin
            check({nm, "_busy_cycles"}, nb, 8);
            check({nm, "_sum"}, sum8, es);
            check({nm, "_cout"}, cout8, ec);
            check({nm, "_busy_at_done"}, busy8, 0);
            @(negedge clk);
            check({nm, "_done_pulse_len"}, done8, 0);
        end
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
        logic [4:0] expv;
        bit seen;
        expv = 5'(ta) + 5'(tb_) + 5'(tc);
        @(negedge clk);
        s4 = 1'b1; a4 = ta; b4 = tb_; c4 = tc;
        @(negedge clk);
        s4 = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done4) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) timeout("w4_exhaustive");
        else check("w4_exhaustive", {cout4, sum4}, expv);
    endtask

    initial begin
        int dn, nb, got, prev;
        logic [7:0] dsum;
        logic [8:0] expq[$];
        logic [8:0] e9;
        logic [7:0] ra, rb;
        logic       rc;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        s8 = 0; a8 = '0; b8 = '0; c8 = 0;
        s4 = 0; a4 = '0; b4 = '0; c4 = 0;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_sum", sum8, 0);
        check("reset_cout", cout8, 0);

        for (int i = 0; i < 6; i++)
            op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].exp_sum, vecs[i].exp_cout);

        // Second start during RUN must be ignored and not queued.
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        nb = 0; dn = 0; dsum = '0;
        for (int i = 0; i < 30; i++) begin
            if (i == 2) begin s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; end
            if (i == 3) s8 = 1'b0;
            if (busy8) nb++;
            if (done8) begin dn++; dsum = sum8; end
            @(negedge clk);
        end
        check("restart_done_count", dn, 1);
        check("restart_busy_cycles", nb, 8);
        check("restart_sum", dsum, 8'h46);

        // Start held high: a new operand pair is presented in every DONE cycle.
        got = 0;
        prev = 0;
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        s8 = 1'b1; a8 = ra; b8 = rb; c8 = rc;
        expq.push_back(9'(ra) + 9'(rb) + 9'(rc));
        for (int c = 0; c < 200 && got < 6; c++) begin
            @(negedge clk);
            if (done8) begin
                e9 = expq.pop_front();
                check("b2b_result", {cout8, sum8}, e9);
                check("b2b_no_busy", busy8, 0);
                if (got > 0) check("b2b_interval", c - prev, 9);
                prev = c;
                got++;
                if (got < 6) begin
                    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
                    a8 = ra; b8 = rb; c8 = rc;
                    expq.push_back(9'(ra) + 9'(rb) + 9'(rc));
                end else begin
                    s8 = 1'b0;
                end
            end
        end
        if (got < 6) begin
            timeout("b2b");
            s8 = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset during the fourth RUN cycle aborts the addition.
        @(negedge clk);
        s8 = 1'b1; a8 = 8'hC3; b8 = 8'h5D; c8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_sum", sum8, 0);
        check("abort_cout", cout8, 0);
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8 || busy8) dn++;
            @(negedge clk);
        end
        check("abort_no_activity", dn, 0);
        op8("after_abort", 8'hC3, 8'h5D, 1'b1, 8'h21, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            e9 = 9'(ra) + 9'(rb) + 9'(rc);
            op8("random", ra, rb, rc, e9[7:0], e9[8]);
        end

        for (int v = 0; v < 512; v++) begin
            e9 = 9'(v);
            op4(e9[3:0], e9[7:4], e9[8]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder with a start/busy/done handshake.
- Latches two operands and a carry-in, then feeds one bit pair per clock (LSB first) into a single 1-bit full-adder cell (full_adder_structural).
- The carry-out of that cell is registered and fed back as the next cycle's carry-in.
- Serves as the sequential front end that drives the team's combinational full-adder cell. It trades WIDTH cycles of latency for one adder cell.

Parameters:
- WIDTH, 8: operand and result width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition. Sampled only in IDLE or DONE.
- a  input  WIDTH  operand A. Sampled on the accepting edge only.
- b  input  WIDTH  operand B. Sampled on the accepting edge only.
- cin  input  1  carry-in. Sampled on the accepting edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: sum/cout were updated on the previous edge.
- sum  output  WIDTH  registered result, held until the next completion.
- cout  output  1  registered final carry, held until the next completion.

Behaviour:
- Reset (rst=1 at a rising edge) has priority over everything else and forces:
  - state=IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - shift registers, carry register and bit counter all 0.
- Reset mid-RUN aborts the operation. No done pulse is produced, and sum/cout are cleared.
- Internal registers:
  - a_sr, b_sr (WIDTH): operand shift registers.
  - s_sr (WIDTH): partial-sum shift register.
  - c_reg (1): carry register.
  - cnt: bit counter, width $clog2(WIDTH)+1.
- State machine:
  - IDLE: if start=1, accept: a_sr<=a, b_sr<=b, c_reg<=cin, cnt<=0, s_sr<=0, then go to RUN. Otherwise stay in IDLE.
  - RUN: busy=1. The full-adder cell sees inputs a_sr[0], b_sr[0], c_reg. On each edge:
    - a_sr and b_sr shift right (0 enters at the MSB);
    - s_sr shifts right with the cell's sum bit entering at the MSB;
    - c_reg <= cell carry;
    - cnt <= cnt+1.
    - On the edge where cnt == WIDTH-1 (the WIDTH-th bit): sum <= {cell sum bit, s_sr[WIDTH-1:1]}, cout <= cell carry, then go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle.
    - If start=1, accept exactly as IDLE does and go to RUN (back-to-back operation).
    - Otherwise go to IDLE.
- Timing:
  - If start is accepted at edge k, busy is high during the WIDTH cycles after edges k..k+WIDTH-1.
  - sum/cout update at edge k+WIDTH.
  - done is high for the single cycle after edge k+WIDTH.
  - Throughput is one result per WIDTH+1 cycles with start held high.
- Start handling:
  - start asserted while busy=1 is ignored.
  - Operand changes during RUN have no effect.
- Output stability: sum/cout change only at the completion edge or on reset. They are never partially updated during RUN.
- Arithmetic: {cout,sum} == a + b + cin, computed modulo 2^(WIDTH+1). There are no overflow flags.
- busy and done are never high in the same cycle.

Test Plan:
- WIDTH=8, start with a=0x5A, b=0x3C, cin=0:
  - busy is high for exactly 8 cycles;
  - done pulses one cycle later with sum=0x96, cout=0.
- Wrap-around carry:
  - 0xFF+0x01, cin=0 -> sum=0x00, cout=1.
  - 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1.
  - 0x00+0x00, cin=1 -> sum=0x01, cout=0.
- start re-pulsed during RUN with different operands:
  - the original result is delivered;
  - exactly one done pulse occurs;
  - the second start is not queued.
- start held high continuously with new operands presented in each DONE cycle:
  - results arrive every 9 cycles;
  - each result matches its own operands.
- rst asserted at cycle 4 of RUN:
  - next cycle shows busy=0, done=0, sum=0, cout=0;
  - no done pulse occurs;
  - a following start completes correctly.
- WIDTH=4 exhaustive check: all 512 combinations of (a, b, cin), each compared against a+b+cin.
